// File: rtl/stopwatch_scan.sv
// BCD stopwatch with lap freeze, saturation flag and a multiplexed common-anode 7-segment scanner.
// Outputs are registered with one cycle of latency; pulse inputs are always accepted, with no backpressure.
module stopwatch_scan #(
  parameter int TICK_DIV = 500000,
  parameter int SCAN_DIV = 32768,
  parameter int NDIG     = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic              LAP,
  output logic              RUN,
  output logic              LAP_ACTIVE,
  output logic              WARN,
  output logic [4*NDIG-1:0] count_bcd,
  output logic [NDIG-1:0]   display,
  output logic [7:0]        out_display
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NDIG);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NDIG - 1);

  logic              r_run;
  logic              r_lap_active;
  logic              r_warn;
  logic [4*NDIG-1:0] r_count;
  logic [4*NDIG-1:0] r_lap;
  logic [PW-1:0]     r_presc;
  logic [SW-1:0]     r_scan;
  logic [IW-1:0]     r_idx;
  logic [NDIG-1:0]   r_display;
  logic [7:0]        r_seg;

  logic              w_tick;
  logic              w_sat;
  logic [4*NDIG-1:0] w_inc;
  logic [4*NDIG-1:0] w_shown;
  logic [IW-1:0]     w_idx_nxt;
  logic [3:0]        w_dig;
  logic              w_dp;
  logic [7:0]        w_seg;

  // Tens-of-seconds and tens-of-minutes digits are base 6; all others base 10.
  function automatic logic [3:0] dig_max(input int i);
    return (i == 3 || i == 5) ? 4'd5 : 4'd9;
  endfunction

  assign w_tick = r_run && (r_presc == P_LAST);

  // Single-cycle ripple increment; a carry out of the top digit means the count is already at maximum.
  always_comb begin : incr
    logic c;
    c     = 1'b1;
    w_inc = r_count;
    for (int i = 0; i < NDIG; i++) begin
      if (c) begin
        if (r_count[4*i +: 4] == dig_max(i)) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    w_sat = c;
  end

  assign w_shown   = r_lap_active ? r_lap : r_count;
  assign w_idx_nxt = (r_scan != S_LAST) ? r_idx :
                     (r_idx == I_LAST)  ? '0 : r_idx + IW'(1);

  always_comb begin
    w_dig = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == w_idx_nxt) w_dig = w_shown[4*i +: 4];
    end
  end

  assign w_dp = (int'(w_idx_nxt) == 2) || (int'(w_idx_nxt) == 4) || (int'(w_idx_nxt) == 6);

  always_comb begin
    case (w_dig)
      4'd0:    w_seg = 8'hC0;
      4'd1:    w_seg = 8'hF9;
      4'd2:    w_seg = 8'hA4;
      4'd3:    w_seg = 8'hB0;
      4'd4:    w_seg = 8'h99;
      4'd5:    w_seg = 8'h92;
      4'd6:    w_seg = 8'h82;
      4'd7:    w_seg = 8'hF8;
      4'd8:    w_seg = 8'h80;
      4'd9:    w_seg = 8'h90;
      default: w_seg = 8'hFF;
    endcase
    if (w_dp && w_dig <= 4'd9) w_seg[7] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_run        <= 1'b0;
      r_lap_active <= 1'b0;
      r_warn       <= 1'b0;
      r_count      <= '0;
      r_lap        <= '0;
      r_presc      <= '0;
      r_scan       <= '0;
      r_idx        <= '0;
      r_display    <= ~NDIG'(1);
      r_seg        <= 8'hC0;
    end else begin
      if (START && !r_warn) r_run <= ~r_run;
      // Prescaler only advances while running so a paused partial tick survives resume.
      if (r_run) r_presc <= (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        if (w_sat) begin
          r_warn <= 1'b1;
          r_run  <= 1'b0;
        end else begin
          r_count <= w_inc;
        end
      end
      if (LAP) begin
        if (!r_lap_active) r_lap <= r_count;
        r_lap_active <= ~r_lap_active;
      end
      r_scan    <= (r_scan == S_LAST) ? '0 : r_scan + SW'(1);
      r_idx     <= w_idx_nxt;
      // Anode and segments are loaded from the same next index so they always switch together.
      r_display <= ~(NDIG'(1) << w_idx_nxt);
      r_seg     <= w_seg;
    end
  end

  assign RUN         = r_run;
  assign LAP_ACTIVE  = r_lap_active;
  assign WARN        = r_warn;
  assign count_bcd   = r_count;
  assign display     = r_display;
  assign out_display = r_seg;

endmodule

// File: tb/tb_stopwatch_scan.sv
// Directed bench for stopwatch_scan: a 4-digit instance and a 6-digit instance share one clock.
module tb_stopwatch_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr4 = 1'b1, start4 = 1'b0, lap4 = 1'b0;
  logic        run4, lapa4, warn4;
  logic [15:0] cnt4;
  logic [3:0]  disp4;
  logic [7:0]  seg4;

  logic        clr6 = 1'b1, start6 = 1'b0, lap6 = 1'b0;
  logic        run6, lapa6, warn6;
  logic [23:0] cnt6;
  logic [5:0]  disp6;
  logic [7:0]  seg6;

  stopwatch_scan #(.TICK_DIV(4), .SCAN_DIV(2), .NDIG(4)) u_dut4 (
    .CLK(clk), .CLR(clr4), .START(start4), .LAP(lap4),
    .RUN(run4), .LAP_ACTIVE(lapa4), .WARN(warn4),
    .count_bcd(cnt4), .display(disp4), .out_display(seg4)
  );

  stopwatch_scan #(.TICK_DIV(2), .SCAN_DIV(1), .NDIG(6)) u_dut6 (
    .CLK(clk), .CLR(clr6), .START(start6), .LAP(lap6),
    .RUN(run6), .LAP_ACTIVE(lapa6), .WARN(warn6),
    .count_bcd(cnt6), .display(disp6), .out_display(seg6)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr4_pulse();
    clr4 = 1'b1; @(negedge clk); clr4 = 1'b0;
  endtask

  task automatic start4_pulse();
    start4 = 1'b1; @(negedge clk); start4 = 1'b0;
  endtask

  task automatic lap4_pulse();
    lap4 = 1'b1; @(negedge clk); lap4 = 1'b0;
  endtask

  // Watch one full scan round and record the segments shown under each anode.
  task automatic scan4(input string tag, input logic [31:0] exp_segs);
    logic [7:0] seen [4];
    logic [3:0] sel;
    for (int i = 0; i < 4; i++) seen[i] = 8'h00;
    repeat (8) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        sel = 4'b0001 << i;
        if (disp4 == ~sel) seen[i] = seg4;
      end
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_seg%0d", tag, i), {24'h0, seen[i]}, {24'h0, exp_segs[8*i +: 8]});
  endtask

  logic [3:0] exp_d4 [8] = '{4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE};
  logic [7:0] exp_s4 [8] = '{8'hC0, 8'hC0, 8'hC0, 8'h40, 8'h40, 8'hC0, 8'hC0, 8'hC0};
  logic [5:0] exp_d6 [8] = '{6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3E, 6'h3D, 6'h3B};
  logic [7:0] exp_s6 [8] = '{8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'hC0, 8'hC0, 8'h40};

  initial begin
    @(negedge clk);
    chk("rst_run",   run4,  0);
    chk("rst_lap",   lapa4, 0);
    chk("rst_warn",  warn4, 0);
    chk("rst_count", cnt4,  0);
    chk("rst_disp",  disp4, 4'hE);
    chk("rst_seg",   seg4,  8'hC0);
    clr4 = 1'b0;
    clr6 = 1'b0;

    // Scan order and decimal point on an idle zero count.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("scan4_disp%0d", k), disp4, exp_d4[k]);
      chk($sformatf("scan4_seg%0d", k),  seg4,  exp_s4[k]);
      chk($sformatf("scan6_disp%0d", k), disp6, exp_d6[k]);
      chk($sformatf("scan6_seg%0d", k),  seg6,  exp_s6[k]);
    end

    // Basic count: 40 running edges at 4 clocks per tick.
    clr4_pulse();
    start4_pulse();
    edges(40);
    chk("basic_count", cnt4,  16'h0010);
    chk("basic_run",   run4,  1);
    chk("basic_warn",  warn4, 0);

    // Pause keeps the partial tick.
    clr4_pulse();
    start4_pulse();
    edges(5);
    start4_pulse();
    chk("pause_stop_run", run4, 0);
    edges(20);
    chk("pause_hold", cnt4, 16'h0001);
    start4_pulse();
    chk("resume_run", run4, 1);
    chk("resume_0", cnt4, 16'h0001);
    edges(1);
    chk("resume_1", cnt4, 16'h0001);
    edges(1);
    chk("resume_2", cnt4, 16'h0002);

    // Lap freeze at 0.25 while counting continues.
    clr4_pulse();
    start4_pulse();
    edges(100);
    chk("lap_pre", cnt4, 16'h0025);
    lap4_pulse();
    chk("lap_on", lapa4, 1);
    scan4("lap_frozen", {8'hC0, 8'h40, 8'hA4, 8'h92});
    chk("lap_live", cnt4, 16'h0027);
    start4_pulse();
    lap4_pulse();
    chk("lap_off", lapa4, 0);
    scan4("lap_live", {8'hC0, 8'h40, 8'hA4, 8'hF8});

    // Carry through seconds into minutes on the 6-digit instance.
    start6 = 1'b1; @(negedge clk); start6 = 1'b0;
    edges(11998);
    chk("carry_pre",  cnt6, 24'h005999);
    edges(2);
    chk("carry_post", cnt6, 24'h010000);
    chk("carry_run",  run6, 1);

    // Saturation at 59.99 on the 4-digit instance.
    clr4_pulse();
    start4_pulse();
    edges(23996);
    chk("sat_pre", cnt4, 16'h5999);
    edges(3);
    chk("sat_pre_warn", warn4, 0);
    edges(1);
    chk("sat_count", cnt4,  16'h5999);
    chk("sat_warn",  warn4, 1);
    chk("sat_run",   run4,  0);
    start4_pulse();
    chk("sat_start_ignored", run4, 0);
    edges(10);
    chk("sat_hold", cnt4, 16'h5999);
    clr4_pulse();
    chk("sat_clr_warn", warn4, 0);

    // Reset wins over START and LAP while lapped at 12.34.
    start4_pulse();
    edges(4936);
    chk("prio_pre", cnt4, 16'h1234);
    lap4_pulse();
    chk("prio_lap", lapa4, 1);
    clr4 = 1'b1; start4 = 1'b1; lap4 = 1'b1;
    @(negedge clk);
    clr4 = 1'b0; start4 = 1'b0; lap4 = 1'b0;
    chk("prio_count", cnt4,  0);
    chk("prio_run",   run4,  0);
    chk("prio_lapa",  lapa4, 0);
    chk("prio_warn",  warn4, 0);
    chk("prio_disp",  disp4, 4'hE);
    chk("prio_seg",   seg4,  8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_scan.md
Name: stopwatch_scan

Overview:
- Parametrised successor to the 4-digit centisecond stopwatch.
- BCD elapsed-time counter with a configurable digit count (hundredths, seconds, minutes, hours) and a start/stop toggle.
- Lap freeze: the display holds while counting continues.
- Saturates with a warning flag and drives a multiplexed common-anode 7-segment display.
- Sits between the debounced button synchronisers and the board's anode/segment pins.

Parameters:
- TICK_DIV, 500000: CLK cycles per 1/100 s tick; must be >= 2.
- SCAN_DIV, 32768: CLK cycles each digit stays enabled during scanning; must be >= 1.
- NDIG, 4: number of digits; legal values are 4, 6 and 8.

Ports:
- CLK  in  1  system clock.
- CLR  in  1  synchronous active-high reset.
- START  in  1  single-cycle pulse; toggles run/stop.
- LAP  in  1  single-cycle pulse; toggles lap freeze.
- RUN  out  1  1 while counting.
- LAP_ACTIVE  out  1  1 while the display shows the frozen lap value.
- WARN  out  1  1 when the count is saturated at maximum.
- count_bcd  out  4*NDIG  live count, digit 0 in bits [3:0].
- display  out  NDIG  anode enables, active-low, one-hot-zero.
- out_display  out  8  segments: bit7 = DP, bits[6:0] = g..a, all active-low.

Behaviour:
- Reset (CLR=1 at a CLK edge, wins over all inputs):
  - count, lap register, prescaler and scan counters go to 0.
  - RUN=0, LAP_ACTIVE=0, WARN=0.
  - display = all ones except bit0 = 0.
  - out_display = 8'hC0.
- Digit layout and bases:
  - d0, d1: hundredths, base 10.
  - d2: seconds units, base 10; d3: seconds tens, base 6.
  - d4: minutes units, base 10; d5: minutes tens, base 6 (NDIG >= 6).
  - d6, d7: hours, base 10 each (NDIG = 8).
- Maximum value: all digits at their base-1. NDIG=4 gives 59.99; NDIG=6 gives 59:59.99; NDIG=8 gives 99:59:59.99.
- Run control:
  - START while WARN=0 toggles RUN on the next edge.
  - START while WARN=1 is ignored; only CLR recovers from saturation.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while RUN=1.
  - Holds its value (not cleared) while stopped, so the partial tick is preserved across pause/resume.
- Increment:
  - On the edge where RUN=1 and prescaler == TICK_DIV-1: prescaler wraps to 0 and the count increments by one hundredth.
  - Ripple carry propagates through all digits in the same edge; there is no multi-cycle carry.
- Saturation:
  - An increment that would exceed the maximum instead leaves the count at maximum, sets WARN=1 and clears RUN on that same edge.
  - WARN is registered and stays 1 until CLR.
- Lap:
  - LAP while LAP_ACTIVE=0 copies the current count (pre-increment value if a tick coincides) into the lap register and sets LAP_ACTIVE.
  - LAP while LAP_ACTIVE=1 clears LAP_ACTIVE.
  - LAP is accepted whether running or stopped.
- Simultaneous START and LAP: both take effect on the same edge, independently.
- Shown value: the lap register when LAP_ACTIVE=1, otherwise the count. count_bcd always carries the live count.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1 continuously, independent of RUN.
  - At terminal count the digit index advances, wrapping from NDIG-1 to 0.
  - display = ~(1 << index), registered.
  - out_display is registered in the same edge as display, so the anode and its segments always change together with no one-cycle mismatch.
- Segment codes (bits[6:0], with bit7 shown as 1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Decimal point: bit7 = 0 when index is 2, 4 or 6 (digit exists), marking the s/min/h boundaries; otherwise bit7 = 1.
- Digit values 10-15 never occur and decode to FF (blank).
- CLR asserted mid-count or mid-lap: everything returns to the reset state on that edge, with no residual lap or WARN.

Test Plan:
- Basic count (TICK_DIV=4, SCAN_DIV=2, NDIG=4): CLR, then START, run 40 cycles -> count_bcd = 16'h0010, RUN=1, WARN=0.
- Pause preserves the partial tick: START, wait 6 cycles (prescaler=2), START again (stop), wait 20 cycles, START -> first increment arrives 2 cycles after resume; count unchanged while stopped.
- Carry and bases (NDIG=6): preload by running to 00:59.99, give one tick -> count_bcd = 24'h010000. At 59:59.99 one tick -> stays 24'h595999, WARN=1, RUN=0; a subsequent START leaves RUN=0.
- Lap freeze: run to 0.25, pulse LAP -> LAP_ACTIVE=1 and the displayed digits stay 0025 while count_bcd keeps advancing. LAP again -> the display follows the live count.
- Scan order and DP (NDIG=4, SCAN_DIV=2):
  - display sequences E, D, B, 7, E, changing every 2 cycles.
  - With count 0 at index 2, out_display = 8'h40; at every other index it is 8'hC0.
- Reset priority: CLR asserted together with START and LAP while at 12.34 with LAP_ACTIVE=1 -> next edge gives count 0, RUN=0, LAP_ACTIVE=0, WARN=0, display=E, out_display=C0.
